// File: rtl/aes_core_arbiter.sv
// Round-robin front end that time-shares one AES-128 core between NUM_REQ requesters.
// Optional watchdog in WAIT enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*128-1:0]   req_text,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [127:0]             rsp_text,
   output logic                     rsp_err,
   output logic [127:0]             core_text,
   output logic                     core_start,
   input  logic                     core_done,
   input  logic [127:0]             core_cipher,
   output logic                     busy
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("aes_core_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ID_W-1:0]   r_last_grant;
   logic [ID_W-1:0]   r_id;
   logic [127:0]      r_core_text;
   logic [ID_W-1:0]   r_rsp_id;
   logic [127:0]      r_rsp_text;
   logic              r_rsp_err;
   logic              r_done_armed;

   logic              w_hi_hit;
   logic              w_lo_hit;
   logic [ID_W-1:0]   w_hi_idx;
   logic [ID_W-1:0]   w_lo_idx;
   logic [127:0]      w_hi_text;
   logic [127:0]      w_lo_text;
   logic              w_grant_any;
   logic [ID_W-1:0]   w_grant_idx;
   logic [127:0]      w_grant_text;
   logic [NUM_REQ-1:0] w_grant;
   logic              w_accept;
   logic              w_done_ok;
   logic              w_timeout;

   // Rotating priority split into two ascending scans: indices above last_grant
   // win over indices at or below it, which equals a search from last_grant+1.
   always_comb begin
      w_hi_hit  = 1'b0;
      w_lo_hit  = 1'b0;
      w_hi_idx  = '0;
      w_lo_idx  = '0;
      w_hi_text = '0;
      w_lo_text = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && (i > 32'(r_last_grant)) && !w_hi_hit) begin
            w_hi_hit  = 1'b1;
            w_hi_idx  = ID_W'(i);
            w_hi_text = req_text[i*128 +: 128];
         end
         if (req_valid[i] && (i <= 32'(r_last_grant)) && !w_lo_hit) begin
            w_lo_hit  = 1'b1;
            w_lo_idx  = ID_W'(i);
            w_lo_text = req_text[i*128 +: 128];
         end
      end
      w_grant_any  = w_hi_hit | w_lo_hit;
      w_grant_idx  = w_hi_hit ? w_hi_idx  : w_lo_idx;
      w_grant_text = w_hi_hit ? w_hi_text : w_lo_text;
   end

   assign w_grant   = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
   assign w_accept  = (r_state == S_IDLE) && w_grant_any && !rst;
   assign req_ready = w_accept ? w_grant : '0;
   assign w_done_ok = (r_state == S_WAIT) && core_done && r_done_armed;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (rst || r_state == S_LAUNCH) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a qualifying Done takes precedence.
   assign w_timeout = (r_state == S_WAIT) && (32'(r_wait_cnt) == TIMEOUT_CYCLES - 1);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_LAUNCH;
         S_LAUNCH: w_next = S_WAIT;
         S_WAIT:   if (w_done_ok || w_timeout) w_next = S_RESP;
         S_RESP:   if (rsp_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_id         <= '0;
         r_core_text  <= '0;
         r_rsp_id     <= '0;
         r_rsp_text   <= '0;
         r_rsp_err    <= 1'b0;
         r_done_armed <= 1'b0;
      end else begin
         if (w_accept) begin
            r_core_text  <= w_grant_text;
            r_id         <= w_grant_idx;
            r_last_grant <= w_grant_idx;
         end
         // A Done only counts once it has been seen low after the launch.
         if (r_state == S_LAUNCH) begin
            r_done_armed <= 1'b0;
         end else if (r_state == S_WAIT && !core_done) begin
            r_done_armed <= 1'b1;
         end
         if (w_done_ok) begin
            r_rsp_text <= core_cipher;
            r_rsp_id   <= r_id;
            r_rsp_err  <= 1'b0;
         end else if (w_timeout) begin
            r_rsp_text <= '0;
            r_rsp_id   <= r_id;
            r_rsp_err  <= 1'b1;
         end
      end
   end

   assign core_text  = r_core_text;
   assign core_start = (r_state == S_LAUNCH);
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_id     = r_rsp_id;
   assign rsp_text   = r_rsp_text;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: vector table, directed corner cases and
// randomized transactions against a round-robin/core reference model.
module tb_aes_core_arbiter;
   localparam int NR = 4;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*128-1:0] req_text;
   logic [NR-1:0]    req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [127:0]     rsp_text;
   logic             rsp_err;
   logic [127:0]     core_text;
   logic             core_start;
   logic             core_done;
   logic [127:0]     core_cipher;
   logic             busy;

   aes_core_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_text(req_text),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_text(rsp_text), .rsp_err(rsp_err),
      .core_text(core_text), .core_start(core_start), .core_done(core_done),
      .core_cipher(core_cipher), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int model_last;
   bit use_fips;
   logic [127:0] lane [NR];

   typedef struct {
      logic [3:0] mask;
      int         exp_id;
      int         stale;
      int         dly;
      int         rdy;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Stand-in for the AES core: the FIPS-197 vector, otherwise a cheap bijection.
   function automatic logic [127:0] cipher_of(input logic [127:0] t);
      if (t == FIPS_PT) return FIPS_CT;
      return {t[63:0], t[127:64]} ^ 128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0;
   endfunction

   function automatic int rr_pick(input int last, input logic [3:0] m);
      for (int d = 1; d <= NR; d++) begin
         if (((m >> ((last + d) % NR)) & 4'd1) != 4'd0) return (last + d) % NR;
      end
      return -1;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge with the DUT in IDLE.
   task automatic run_txn(input logic [3:0] mask, input int exp_id,
                          input int stale, input int dly, input int rdy);
      logic [127:0] exp_t, exp_c;
      int waited;
      bit early, moved;
      for (int i = 0; i < NR; i++) lane[i] = rnd128();
      if (use_fips) lane[0] = FIPS_PT;
      req_text  = {lane[3], lane[2], lane[1], lane[0]};
      req_valid = mask;
      rsp_ready = 1'b0;
      #1;
      waited = 0;
      while (req_ready == '0 && waited < 8) begin
         @(negedge clk); #1;
         waited++;
      end
      chk("grant_onehot", req_ready, 4'b0001 << exp_id);
      chk("grant_latency", waited, 0);
      exp_t = lane[exp_id];
      exp_c = cipher_of(exp_t);
      @(negedge clk);
      req_valid = '0;
      chk("launch_start", core_start, 1'b1);
      chk("launch_text", core_text, exp_t);
      chk("launch_ready", req_ready, 0);
      early = 1'b0;
      for (int k = 0; k <= stale; k++) begin
         core_done   = (stale > 0);
         core_cipher = rnd128();
         @(negedge clk);
         if (rsp_valid || core_start) early = 1'b1;
      end
      for (int k = 0; k <= dly; k++) begin
         core_done = 1'b0;
         @(negedge clk);
         if (rsp_valid || core_start) early = 1'b1;
      end
      core_done   = 1'b1;
      core_cipher = exp_c;
      if (rdy == 0) rsp_ready = 1'b1;
      @(negedge clk);
      core_done   = 1'b0;
      core_cipher = rnd128();
      chk("no_early_rsp", early, 1'b0);
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_text", rsp_text, exp_c);
      chk("rsp_err", rsp_err, 1'b0);
      if (rdy > 0) begin
         moved = 1'b0;
         req_valid = 4'hF;
         repeat (rdy) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_text !== exp_c || req_ready !== '0)
               moved = 1'b1;
         end
         chk("resp_hold", moved, 1'b0);
         req_valid = '0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
      chk("idle_after_rsp", busy, 1'b0);
      model_last = exp_id;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 4'hF;
      @(negedge clk); #1;
      chk("ready_in_reset", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      model_last = NR - 1;
   endtask

   initial begin
      int cnt;
      bit flag;
      logic [3:0] m;
      int e;
      tbl[0]  = '{4'b0001, 0, 0, 2, 3};
      tbl[1]  = '{4'b1111, 1, 3, 0, 0};
      tbl[2]  = '{4'b1111, 2, 0, 0, 10};
      tbl[3]  = '{4'b1111, 3, 1, 1, 1};
      tbl[4]  = '{4'b1111, 0, 0, 3, 0};
      tbl[5]  = '{4'b1010, 1, 2, 0, 2};
      tbl[6]  = '{4'b1010, 3, 0, 1, 0};
      tbl[7]  = '{4'b0110, 1, 0, 0, 1};
      tbl[8]  = '{4'b0100, 2, 1, 2, 0};
      tbl[9]  = '{4'b1001, 3, 0, 0, 0};
      tbl[10] = '{4'b1001, 0, 2, 1, 1};
      tbl[11] = '{4'b1000, 3, 0, 0, 0};

      rst = 1'b1; req_valid = '0; req_text = '0; rsp_ready = 1'b0;
      core_done = 1'b0; core_cipher = '0; use_fips = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_core_text", core_text, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_text", rsp_text, 0);
      chk("rst_rsp_err", rsp_err, 1'b0);

      for (int i = 0; i < 12; i++) begin
         use_fips = (i == 0);
         run_txn(tbl[i].mask, tbl[i].exp_id, tbl[i].stale, tbl[i].dly, tbl[i].rdy);
      end
      use_fips = 1'b0;

      do_reset();
      for (int i = 0; i < 8; i++) run_txn(4'b1111, i % NR, i % 3, 1, i % 2);

      for (int i = 0; i < 30; i++) begin
         m = 4'($urandom_range(1, 15));
         e = rr_pick(model_last, m);
         run_txn(m, e, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
      end

      // Reset while waiting on the core, then a late Done must be ignored.
      e = rr_pick(model_last, 4'b0010);
      req_valid = 4'b0010; #1;
      chk("rw_grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      core_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rw_in_wait", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_busy", busy, 1'b0);
      chk("rw_core_start", core_start, 1'b0);
      chk("rw_core_text", core_text, 0);
      chk("rw_rsp_valid", rsp_valid, 1'b0);
      chk("rw_rsp_id", rsp_id, 0);
      chk("rw_rsp_text", rsp_text, 0);
      chk("rw_rsp_err", rsp_err, 1'b0);
      core_done = 1'b1; core_cipher = rnd128();
      repeat (2) @(negedge clk);
      core_done = 1'b0;
      flag = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid || busy) flag = 1'b1;
      end
      chk("rw_late_done_ignored", flag, 1'b0);
      model_last = NR - 1;
      run_txn(4'b1111, 0, 0, 0, 0);

      // Core never answers.
      e = rr_pick(model_last, 4'b0100);
      req_valid = 4'b0100; #1;
      chk("to_grant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      core_done = 1'b0;
      cnt = 0;
`ifdef AES_ARB_TIMEOUT_EN
      while (!rsp_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("to_cycles", cnt, 17);
      chk("to_err", rsp_err, 1'b1);
      chk("to_text", rsp_text, 0);
      chk("to_id", rsp_id, e);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("to_idle", busy, 1'b0);
`else
      flag = 1'b0;
      while (cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (rsp_valid || !busy || rsp_err) flag = 1'b1;
      end
      chk("wait_forever", flag, 1'b0);
      chk("wait_busy", busy, 1'b1);
      do_reset();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1);
   end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES-128 encryption core (128-bit text in, start/Done handshake, 128-bit cipher out) between NUM_REQ independent requesters.
- Round-robin arbitration with valid/ready on each request port and a single tagged response channel.
- Sequences the core: latches the plaintext, pulses start, waits for a fresh Done, captures the cipher, returns it with the requester ID.
- Sits between client logic and the AES top-level core instance.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with AES_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_text  in  NUM_REQ*128  plaintexts; requester i occupies bits [i*128 +: 128]
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the served requester
- rsp_text  out  128  ciphertext
- rsp_err  out  1  timeout flag (constant 0 without the macro)
- core_text  out  128  plaintext to the core
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core Done
- core_cipher  in  128  core Cipheredtext
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, core_start=0, core_text=0, rsp_valid=0, rsp_id=0, rsp_text=0, rsp_err=0, busy=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- req_ready is 0 during any cycle with rst=1. Reset mid-operation abandons the transaction; the core output is ignored until the next launch.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Combinational grant picks the first requester with req_valid=1, searching from last_grant+1 modulo NUM_REQ.
  - req_ready is the one-hot grant while in IDLE and 0 in all other states. At most one bit is set per cycle.
  - On handshake: latch req_text[i] into core_text and i into the ID register, set last_grant=i, go to LAUNCH.
  - With no valid request, remain in IDLE.
- LAUNCH:
  - core_start=1 for exactly this cycle; core_text holds until the next accept.
  - Clear done_armed; go to WAIT.
- WAIT:
  - core_done sampled 0 sets done_armed.
  - core_done sampled 1 with done_armed=1: capture core_cipher into rsp_text, set rsp_id, rsp_err=0, go to RESP.
  - core_done high while done_armed=0 is a stale Done from the previous operation and is ignored.
  - core_done is ignored outside WAIT.
- RESP:
  - rsp_valid=1; rsp_id, rsp_text and rsp_err are held stable until rsp_valid and rsp_ready are both 1.
  - On that handshake, rsp_valid drops next cycle and the block returns to IDLE.
  - rsp_ready already high on RESP entry completes in one cycle.
- Latency:
  - Accept at cycle T, core_start at T+1, WAIT from T+2.
  - rsp_valid rises the cycle after the qualifying core_done sample.
  - Next accept is possible the cycle after the response handshake.
- Fairness: a continuously-valid requester is served at least once every NUM_REQ transactions.
- req_valid dropping without a handshake is legal and has no effect.
- Only one transaction is in flight; there is no queueing.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- With the macro:
  - A counter resets to 0 on LAUNCH and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before a qualifying Done: enter RESP with rsp_err=1, rsp_text=0, rsp_id=served ID.
  - If a qualifying Done and the timeout occur in the same cycle, the Done wins (rsp_err=0).
- Without the macro: no counter; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset, then req_valid=4'b0001 with FIPS-197 plaintext 00112233445566778899aabbccddeeff -> req_ready[0] pulses, core_start one cycle later; core model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_valid with rsp_id=0 and that cipher, held until rsp_ready.
- req_valid=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready bit per IDLE accept.
- Core model holds Done=1 from the previous op for 3 cycles after start, then low, then high -> completion only on the post-low high; rsp_text matches the new cipher.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_text stable; no req_ready asserted; accept occurs the cycle after the handshake.
- rst=1 during WAIT -> next cycle state=IDLE with all outputs at reset values; a later core_done produces no response.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never asserts Done -> rsp_valid after 16 WAIT cycles with rsp_err=1 and rsp_text=0; without the macro, busy stays 1.
